// File: rtl/cond_unit.sv
// Condition unit: evaluates a 4-bit predicate against two flag banks and
// conditionally updates them. Define COND_UNIT_IT_BLOCK_EN for predication windows.
module cond_unit #(
    parameter int FLAG_W = 2,
    parameter int SEL_W  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic [SEL_W-1:0]  flag_sel,
    input  logic [1:0]        flag_we,
    input  logic [FLAG_W-1:0] alu_flags1,
    input  logic [FLAG_W-1:0] alu_flags2,
    input  logic              it_start,
    input  logic [1:0]        it_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              cond_ex,
    output logic [FLAG_W-1:0] flags1_q,
    output logic [FLAG_W-1:0] flags2_q,
    output logic              it_active
);

    localparam logic [SEL_W:0] FLAG_LIMIT = (SEL_W + 1)'(FLAG_W);

    logic       accept;
    logic       sel_in_range;
    logic       f1;
    logic       f2;
    logic [3:0] eff_cond;
    logic       exec;

    function automatic logic eval_cond(input logic [3:0] c, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (c)
            4'b0000: r = 1'b1;
            4'b0001: r = 1'b0;
            4'b0010: r = a;
            4'b0011: r = b;
            4'b0100: r = ~a;
            4'b0101: r = ~b;
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            4'b1001: r = ~(a ^ b);
            4'b1010: r = ~(a & b);
            4'b1011: r = ~(a | b);
            4'b1100: r = a & ~b;
            4'b1101: r = ~a & b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Selector codes beyond the bank width read as a cleared flag.
    assign sel_in_range = {1'b0, flag_sel} < FLAG_LIMIT;

    always_comb begin
        f1 = 1'b0;
        f2 = 1'b0;
        if (sel_in_range) begin
            f1 = flags1_q[flag_sel];
            f2 = flags2_q[flag_sel];
        end
    end

`ifdef COND_UNIT_IT_BLOCK_EN
    logic [2:0] it_cnt;
    logic [3:0] it_cond;

    // A new it_start always wins over an open window, so restarts take their own cond.
    assign eff_cond  = (!it_start && it_cnt != 3'd0) ? it_cond : cond;
    assign it_active = (it_cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            it_cnt  <= 3'd0;
            it_cond <= 4'd0;
        end else if (accept) begin
            if (it_start) begin
                it_cnt  <= {1'b0, it_len} + 3'd1;
                it_cond <= cond;
            end else if (it_cnt != 3'd0) begin
                it_cnt <= it_cnt - 3'd1;
            end
        end
    end
`else
    logic unused_it;

    assign eff_cond  = cond;
    assign it_active = 1'b0;
    assign unused_it = ^{it_start, it_len};
`endif

    // Evaluated on the pre-update flags, so an instruction never sees its own write.
    assign exec = eval_cond(eff_cond, f1, f2);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            cond_ex   <= 1'b0;
            flags1_q  <= '0;
            flags2_q  <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                cond_ex   <= exec;
                if (exec && flag_we[0]) flags1_q <= alu_flags1;
                if (exec && flag_we[1]) flags2_q <= alu_flags2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed testbench for cond_unit with a scoreboard queue of expected cond_ex values.
module tb_cond_unit;

    localparam int FLAG_W = 3;
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        cond = 4'd0;
    logic [SEL_W-1:0]  flag_sel = '0;
    logic [1:0]        flag_we = 2'b00;
    logic [FLAG_W-1:0] alu_flags1 = '0;
    logic [FLAG_W-1:0] alu_flags2 = '0;
    logic              it_start = 1'b0;
    logic [1:0]        it_len = 2'd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              cond_ex;
    logic [FLAG_W-1:0] flags1_q;
    logic [FLAG_W-1:0] flags2_q;
    logic              it_active;

    int nAsserts = 0;
    int nFails   = 0;

    logic              expQ[$];
    logic [FLAG_W-1:0] mF1 = '0;
    logic [FLAG_W-1:0] mF2 = '0;
    logic              mOv = 1'b0;
    logic              mCex = 1'b0;
    int                mCnt = 0;
    logic [3:0]        mLc = 4'd0;
    logic              lastAcc = 1'b0;

    always #5 clk = ~clk;

    cond_unit #(.FLAG_W(FLAG_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .flag_sel(flag_sel), .flag_we(flag_we),
        .alu_flags1(alu_flags1), .alu_flags2(alu_flags2),
        .it_start(it_start), .it_len(it_len), .out_valid(out_valid),
        .out_ready(out_ready), .cond_ex(cond_ex), .flags1_q(flags1_q),
        .flags2_q(flags2_q), .it_active(it_active)
    );

    // Truth table row per condition: bit {F1,F2} holds the result.
    function automatic logic [3:0] truthRow(input logic [3:0] c);
        case (c)
            4'h0: return 4'hF;
            4'h1: return 4'h0;
            4'h2: return 4'hC;
            4'h3: return 4'hA;
            4'h4: return 4'h3;
            4'h5: return 4'h5;
            4'h6: return 4'h8;
            4'h7: return 4'hE;
            4'h8: return 4'h6;
            4'h9: return 4'h9;
            4'hA: return 4'h7;
            4'hB: return 4'h1;
            4'hC: return 4'h4;
            4'hD: return 4'h2;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic refEval(input logic [3:0] c, input logic a, input logic b);
        logic [3:0] row;
        row = truthRow(c);
        return row[{a, b}];
    endfunction

    function automatic logic refFlag(input logic [FLAG_W-1:0] bank, input logic [SEL_W-1:0] s);
        if (int'(s) >= FLAG_W) return 1'b0;
        return bank[s];
    endfunction

    function automatic logic expActive();
`ifdef COND_UNIT_IT_BLOCK_EN
        return mCnt != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic iv, input logic [3:0] c,
                                 input logic [SEL_W-1:0] s, input logic [1:0] we,
                                 input logic [FLAG_W-1:0] a1, input logic [FLAG_W-1:0] a2,
                                 input logic its, input logic [1:0] itl, input logic ordy);
        logic [3:0] eff;
        logic       e;
        @(negedge clk);
        in_valid = iv; cond = c; flag_sel = s; flag_we = we;
        alu_flags1 = a1; alu_flags2 = a2; it_start = its; it_len = itl; out_ready = ordy;
        #1;
        checkVal({tag, ".in_ready"}, 32'(in_ready), 32'(!mOv || ordy));
        lastAcc = iv && (!mOv || ordy);
        if (lastAcc) begin
            eff = c;
`ifdef COND_UNIT_IT_BLOCK_EN
            if (!its && mCnt != 0) eff = mLc;
`endif
            e = refEval(eff, refFlag(mF1, s), refFlag(mF2, s));
            expQ.push_back(e);
            if (e && we[0]) mF1 = a1;
            if (e && we[1]) mF2 = a2;
`ifdef COND_UNIT_IT_BLOCK_EN
            if (its) begin
                mCnt = int'(itl) + 1;
                mLc  = c;
            end else if (mCnt != 0) begin
                mCnt--;
            end
`endif
            mOv = 1'b1;
        end else if (mOv && ordy) begin
            mOv = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        @(posedge clk);
        #1;
        checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(mOv));
        if (lastAcc) mCex = expQ.pop_front();
        if (mOv) checkVal({tag, ".cond_ex"}, 32'(cond_ex), 32'(mCex));
        checkVal({tag, ".flags1"}, 32'(flags1_q), 32'(mF1));
        checkVal({tag, ".flags2"}, 32'(flags2_q), 32'(mF2));
        checkVal({tag, ".it_active"}, 32'(it_active), 32'(expActive()));
    endtask

    task automatic step(input string tag, input logic iv, input logic [3:0] c,
                        input logic [SEL_W-1:0] s, input logic [1:0] we,
                        input logic [FLAG_W-1:0] a1, input logic [FLAG_W-1:0] a2,
                        input logic its, input logic [1:0] itl, input logic ordy);
        applyStimulus(tag, iv, c, s, we, a1, a2, its, itl, ordy);
        checkOutput(tag);
    endtask

    // Reset with a live, flag-writing instruction offered to prove it is discarded.
    task automatic doReset(input string tag);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; cond = 4'd0; flag_we = 2'b11;
        alu_flags1 = '1; alu_flags2 = '1; it_start = 1'b1; it_len = 2'd3; out_ready = 1'b0;
        mF1 = '0; mF2 = '0; mOv = 1'b0; mCex = 1'b0; mCnt = 0; mLc = 4'd0;
        lastAcc = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1;
        checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(0));
        checkVal({tag, ".cond_ex"}, 32'(cond_ex), 32'(0));
        checkVal({tag, ".flags1"}, 32'(flags1_q), 32'(0));
        checkVal({tag, ".flags2"}, 32'(flags2_q), 32'(0));
        checkVal({tag, ".it_active"}, 32'(it_active), 32'(0));
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; it_start = 1'b0; flag_we = 2'b00; out_ready = 1'b1;
    endtask

    initial begin
        doReset("reset");

        step("first", 1, 4'b0000, 2'd0, 2'b01, 3'b001, 3'b000, 0, 2'd0, 1);
        step("idle1", 0, 4'b0000, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);

        step("b2b_f1",  1, 4'b0010, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("b2b_f2",  1, 4'b0011, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("b2b_and", 1, 4'b0110, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("b2b_xor", 1, 4'b1000, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("b2b_f1n", 1, 4'b1100, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);

        step("never", 1, 4'b0001, 2'd0, 2'b11, 3'b111, 3'b111, 0, 2'd0, 1);

        step("wr_f1",    1, 4'b0000, 2'd0, 2'b01, 3'b111, 3'b000, 0, 2'd0, 1);
        step("dep_sel2", 1, 4'b0010, 2'd2, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("oor_f1",   1, 4'b0010, 2'd3, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("oor_nf1",  1, 4'b0100, 2'd3, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("wr_f2",    1, 4'b0000, 2'd0, 2'b10, 3'b000, 3'b010, 0, 2'd0, 1);
        step("dep_f2",   1, 4'b0011, 2'd1, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        for (int k = 4; k < 16; k++) begin
            step("sweep", 1, 4'(k), 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        end
        step("false_wr", 1, 4'b0101, 2'd1, 2'b11, 3'b000, 3'b000, 0, 2'd0, 1);

        step("bp_load", 1, 4'b0000, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        for (int k = 0; k < 3; k++) begin
            step("bp_hold", 1, 4'b0001, 2'd0, 2'b11, 3'b000, 3'b000, 0, 2'd0, 0);
        end
        step("bp_release", 1, 4'b0001, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("drain", 0, 4'b0000, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);

        step("it_open",  1, 4'b0010, 2'd0, 2'b00, 3'b000, 3'b000, 1, 2'd1, 1);
        step("it_in1",   1, 4'b0001, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("it_in2",   1, 4'b0001, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("it_after", 1, 4'b0001, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("it_long",  1, 4'b0000, 2'd0, 2'b00, 3'b000, 3'b000, 1, 2'd3, 1);
        step("it_gap",   0, 4'b0001, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);
        step("it_rst",   1, 4'b0001, 2'd0, 2'b00, 3'b000, 3'b000, 1, 2'd0, 1);
        step("it_rin",   1, 4'b0000, 2'd0, 2'b01, 3'b010, 3'b000, 0, 2'd0, 1);
        step("it_rout",  1, 4'b0000, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);

        step("mid_open", 1, 4'b0000, 2'd0, 2'b01, 3'b101, 3'b000, 1, 2'd3, 0);
        doReset("mid_reset");
        step("post", 1, 4'b0010, 2'd0, 2'b00, 3'b000, 3'b000, 0, 2'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
